id_stage: RTL and testbench

Decode stage of the multi-cycle RV64I core, directly downstream of the fetch stage. It pairs the fetch PC (from the fetch stage's o_pc/o_valid pulse) with the instruction word returned by instruction memory, which can arrive in either order. It decodes the pair into register addresses, a sign-extended immediate and an operation class. It then presents one registered, single-cycle-valid bundle to the execute stage.

---
 rtl/id_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: pairs the fetch PC with the instruction word (either arrival order),
// decodes the pair and presents a registered, single-cycle-valid bundle to execute.
module id_stage #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_pc,
  input  logic              i_pc_valid,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_inst_valid,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_pc,
  output logic [4:0]        o_rs1_addr,
  output logic [4:0]        o_rs2_addr,
  output logic [4:0]        o_rd_addr,
  output logic [DATA_W-1:0] o_imm,
  output logic [3:0]        o_opclass,
  output logic [2:0]        o_funct3,
  output logic              o_funct7b5,
  output logic              o_illegal,
  output logic              o_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_INST, S_WAIT_PC, S_DECODE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                load_out;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    load_out = 1'b0;
    if (i_flush) begin
      state_d = S_IDLE;
      pc_d    = '0;
      inst_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_pc_valid)   pc_d   = i_pc;
          if (i_inst_valid) inst_d = i_inst;
          if (i_pc_valid && i_inst_valid) state_d = S_DECODE;
          else if (i_pc_valid)            state_d = S_WAIT_INST;
          else if (i_inst_valid)          state_d = S_WAIT_PC;
        end
        S_WAIT_INST: begin
          if (i_pc_valid) pc_d = i_pc;
          if (i_inst_valid) begin
            inst_d  = i_inst;
            state_d = S_DECODE;
          end
        end
        S_WAIT_PC: begin
          if (i_inst_valid) inst_d = i_inst;
          if (i_pc_valid) begin
            pc_d    = i_pc;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          load_out = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Combinational decode of the held instruction
  logic [6:0]        opcode;
  logic [3:0]        dec_opclass;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_rd, dec_rs1, dec_rs2;
  logic              dec_illegal;
  logic              s;

  assign opcode = inst_q[6:0];
  assign s      = inst_q[31];

  always_comb begin
    dec_opclass = 4'd15;
    dec_imm     = '0;
    dec_rd      = inst_q[11:7];
    dec_rs1     = inst_q[19:15];
    dec_rs2     = 5'd0;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0110111: begin
        dec_opclass = 4'd0;
        dec_imm     = {{(DATA_W-32){s}}, inst_q[31:12], 12'b0};
        dec_rs1     = 5'd0;
      end
      7'b0010111: begin
        dec_opclass = 4'd1;
        dec_imm     = {{(DATA_W-32){s}}, inst_q[31:12], 12'b0};
        dec_rs1     = 5'd0;
      end
      7'b1101111: begin
        dec_opclass = 4'd2;
        dec_imm     = {{(DATA_W-21){s}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
        dec_rs1     = 5'd0;
      end
      7'b1100111: begin
        dec_opclass = 4'd3;
        dec_imm     = {{(DATA_W-12){s}}, inst_q[31:20]};
      end
      7'b1100011: begin
        dec_opclass = 4'd4;
        dec_imm     = {{(DATA_W-13){s}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
        dec_rd      = 5'd0;
        dec_rs2     = inst_q[24:20];
      end
      7'b0000011: begin
        dec_opclass = 4'd5;
        dec_imm     = {{(DATA_W-12){s}}, inst_q[31:20]};
      end
      7'b0100011: begin
        dec_opclass = 4'd6;
        dec_imm     = {{(DATA_W-12){s}}, inst_q[31:25], inst_q[11:7]};
        dec_rd      = 5'd0;
        dec_rs2     = inst_q[24:20];
      end
      7'b0010011: begin
        dec_opclass = 4'd7;
        dec_imm     = {{(DATA_W-12){s}}, inst_q[31:20]};
      end
      7'b0110011: begin
        dec_opclass = 4'd8;
        dec_rs2     = inst_q[24:20];
      end
      7'b0011011: begin
        dec_opclass = 4'd9;
        dec_imm     = {{(DATA_W-12){s}}, inst_q[31:20]};
      end
      7'b0111011: begin
        dec_opclass = 4'd10;
        dec_rs2     = inst_q[24:20];
      end
      default: begin
        // Any listed opcode already has inst[1:0]=11, so this covers both illegal cases
        dec_illegal = 1'b1;
        dec_rd      = 5'd0;
        dec_rs1     = 5'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inst_q     <= '0;
      o_pc       <= '0;
      o_rs1_addr <= '0;
      o_rs2_addr <= '0;
      o_rd_addr  <= '0;
      o_imm      <= '0;
      o_opclass  <= '0;
      o_funct3   <= '0;
      o_funct7b5 <= 1'b0;
      o_illegal  <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      o_valid <= load_out;
      if (load_out) begin
        o_pc       <= pc_q;
        o_rs1_addr <= dec_rs1;
        o_rs2_addr <= dec_rs2;
        o_rd_addr  <= dec_rd;
        o_imm      <= dec_imm;
        o_opclass  <= dec_opclass;
        o_funct3   <= inst_q[14:12];
        o_funct7b5 <= inst_q[30];
        o_illegal  <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected bundles queued at stimulus time, popped when o_valid is due.
module tb_id_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [63:0] i_pc = '0;
  logic        i_pc_valid = 1'b0;
  logic [31:0] i_inst = '0;
  logic        i_inst_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic [63:0] o_pc, o_imm;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [3:0]  o_opclass;
  logic [2:0]  o_funct3;
  logic        o_funct7b5, o_illegal, o_valid;

  id_stage #(.ADDR_W(64), .INST_W(32), .DATA_W(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pc(i_pc), .i_pc_valid(i_pc_valid),
    .i_inst(i_inst), .i_inst_valid(i_inst_valid),
    .i_flush(i_flush),
    .o_pc(o_pc), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_rd_addr(o_rd_addr), .o_imm(o_imm), .o_opclass(o_opclass),
    .o_funct3(o_funct3), .o_funct7b5(o_funct7b5), .o_illegal(o_illegal),
    .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  opclass;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [3:0] opc, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                      input logic [2:0] f3, input logic f7b5, input logic ill);
    exp_t e;
    e.pc = pc; e.opclass = opc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.f3 = f3; e.f7b5 = f7b5; e.ill = ill;
    sb.push_back(e);
  endtask

  // Apply strobes for one cycle, then return #1 after the capturing edge
  task automatic drive(input logic pv, input logic [63:0] pc, input logic iv,
                       input logic [31:0] inst, input logic fl);
    i_pc_valid = pv; i_pc = pc; i_inst_valid = iv; i_inst = inst; i_flush = fl;
    @(posedge i_clk); #1;
    i_pc_valid = 1'b0; i_inst_valid = 1'b0; i_flush = 1'b0;
  endtask

  task automatic cmp_bundle(input string tag, input exp_t e);
    chk({tag, ".pc"},      o_pc,       e.pc);
    chk({tag, ".opclass"}, 64'(o_opclass),  64'(e.opclass));
    chk({tag, ".rd"},      64'(o_rd_addr),  64'(e.rd));
    chk({tag, ".rs1"},     64'(o_rs1_addr), 64'(e.rs1));
    chk({tag, ".rs2"},     64'(o_rs2_addr), 64'(e.rs2));
    chk({tag, ".imm"},     o_imm,      e.imm);
    chk({tag, ".f3"},      64'(o_funct3),   64'(e.f3));
    chk({tag, ".f7b5"},    64'(o_funct7b5), 64'(e.f7b5));
    chk({tag, ".illegal"}, 64'(o_illegal),  64'(e.ill));
  endtask

  // Called right after the second strobe's edge (cycle k+1): valid low now, high next, low after
  task automatic expect_out(input string tag);
    exp_t e;
    @(negedge i_clk);
    chk({tag, ".early"}, 64'(o_valid), 64'd0);
    @(negedge i_clk);
    chk({tag, ".valid"}, 64'(o_valid), 64'd1);
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL %s.sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      cmp_bundle(tag, e);
      last = e;
    end
    @(negedge i_clk);
    chk({tag, ".drop"}, 64'(o_valid), 64'd0);
    chk({tag, ".hold_pc"},  o_pc,  last.pc);
    chk({tag, ".hold_imm"}, o_imm, last.imm);
  endtask

  task automatic expect_quiet(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge i_clk);
      chk(tag, 64'(o_valid), 64'd0);
    end
    chk({tag, ".hold_pc"}, o_pc, last.pc);
  endtask

  initial begin
    last = '{default: '0};
    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.pc", o_pc, 64'd0);
    chk("rst.imm", o_imm, 64'd0);
    chk("rst.opclass", 64'(o_opclass), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // In-order: addi x1,x0,5
    drive(1, 64'h100, 0, '0, 0);
    @(negedge i_clk);
    push(64'h100, 4'd7, 5'd1, 5'd0, 5'd0, 64'd5, 3'd0, 1'b0, 1'b0);
    drive(0, '0, 1, 32'h00500093, 0);
    expect_out("addi");

    // Reversed order: beq x1,x2,-8
    drive(0, '0, 1, 32'hFE208CE3, 0);
    push(64'h200, 4'd4, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8, 3'd0, 1'b1, 1'b0);
    drive(1, 64'h200, 0, '0, 0);
    expect_out("beq");

    // Simultaneous: add x3,x1,x2
    push(64'h300, 4'd8, 5'd3, 5'd1, 5'd2, 64'd0, 3'd0, 1'b0, 1'b0);
    drive(1, 64'h300, 1, 32'h002081B3, 0);
    expect_out("add");

    // U/J sign extension
    push(64'h400, 4'd0, 5'd5, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, 3'd0, 1'b0, 1'b0);
    drive(1, 64'h400, 1, 32'h800002B7, 0);
    expect_out("lui");
    push(64'h404, 4'd2, 5'd0, 5'd0, 5'd0, 64'd8, 3'd0, 1'b0, 1'b0);
    drive(1, 64'h404, 1, 32'h0080006F, 0);
    expect_out("jal");

    // Store: sd x2,8(x1)
    drive(1, 64'h500, 0, '0, 0);
    push(64'h500, 4'd6, 5'd0, 5'd1, 5'd2, 64'd8, 3'd3, 1'b0, 1'b0);
    drive(0, '0, 1, 32'h0020B423, 0);
    expect_out("sd");

    // Illegal encodings
    push(64'h40, 4'd15, 5'd0, 5'd0, 5'd0, 64'd0, 3'd7, 1'b1, 1'b1);
    drive(1, 64'h40, 1, 32'hFFFFFFFF, 0);
    expect_out("ill_ones");
    push(64'h44, 4'd15, 5'd0, 5'd0, 5'd0, 64'd0, 3'd0, 1'b0, 1'b1);
    drive(0, '0, 1, 32'h00000000, 0);
    drive(1, 64'h44, 0, '0, 0);
    expect_out("ill_zero");

    // Flush in S_WAIT_INST, with an instruction strobe in the flush cycle
    drive(1, 64'h600, 0, '0, 0);
    drive(0, '0, 1, 32'h00500093, 1);
    expect_quiet("flush_wait", 4);

    // Flush in S_DECODE
    drive(1, 64'h700, 1, 32'h00500093, 0);
    drive(0, '0, 0, '0, 1);
    expect_quiet("flush_dec", 4);

    // Normal pair after flushes, with a repeated PC strobe
    drive(1, 64'h800, 0, '0, 0);
    drive(1, 64'h804, 0, '0, 0);
    push(64'h804, 4'd7, 5'd1, 5'd0, 5'd0, 64'd5, 3'd0, 1'b0, 1'b0);
    drive(0, '0, 1, 32'h00500093, 0);
    expect_out("repc");

    // Async reset while in S_DECODE
    drive(1, 64'h900, 1, 32'h002081B3, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst.pc", o_pc, 64'd0);
    chk("arst.imm", o_imm, 64'd0);
    chk("arst.rd", 64'(o_rd_addr), 64'd0);
    chk("arst.opclass", 64'(o_opclass), 64'd0);
    chk("arst.valid", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    last = '{default: '0};
    expect_quiet("arst_quiet", 4);

    // Decoding resumes after reset
    push(64'hA00, 4'd8, 5'd3, 5'd1, 5'd2, 64'd0, 3'd0, 1'b0, 1'b0);
    drive(1, 64'hA00, 1, 32'h002081B3, 0);
    expect_out("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
